// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus master: data width, FSM encoding and timeout default.
package mem_bus_master_pkg;

  localparam int XLEN               = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_master_timeout.sv
// Access watchdog: counts ACCESS cycles without ready; expired flags the cycle the count reaches LIMIT.
`ifdef BUS_TIMEOUT_EN
module bus_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // This cycle's increment is the one that reaches LIMIT.
  assign expired = inc && (cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_bus_master.sv
// Core-to-memory bus master: IDLE -> ACCESS (hold strobes until ready) -> RELEASE (one cs-low cycle, response pulse).
// Optional access watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wr,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] address,
  output logic [XLEN-1:0] DB_w,
  input  logic [XLEN-1:0] DB_r,
  output logic            wr,
  output logic            rd,
  output logic            cs,
  output logic            valid,
  input  logic            ready
);

  state_t state;
  logic   expired;

  assign req_ready = ~rst & (state != ST_ACCESS);

`ifdef BUS_TIMEOUT_EN
  bus_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != ST_ACCESS),
    .inc    ((state == ST_ACCESS) && !ready),
    .expired(expired)
  );
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cs        <= 1'b0;
      valid     <= 1'b0;
      wr        <= 1'b0;
      rd        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      address   <= '0;
      DB_w      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          if (req_valid) begin
            state   <= ST_ACCESS;
            cs      <= 1'b1;
            valid   <= 1'b1;
            wr      <= req_wr;
            rd      <= ~req_wr;
            address <= req_addr;
            DB_w    <= req_wdata;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          // ready takes priority over a watchdog expiry in the same cycle.
          if (ready || expired) begin
            if (ready && rd) begin
              rsp_rdata <= DB_r;
            end
            rsp_err   <= ~ready;
            rsp_valid <= 1'b1;
            state     <= ST_RELEASE;
            cs        <= 1'b0;
            valid     <= 1'b0;
            wr        <= 1'b0;
            rd        <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
